wait_merge_sync_n: RTL and testbench
====================================

Name: wait_merge_sync_n

Overview:
- Clocked, parameterised N-channel wait-merge (join) for the synchronous islands of the design.
- Each input channel delivers one token over a valid/ready handshake. The block holds every token until all enabled channels have arrived, then emits one concatenated word downstream.
- A per-channel enable mask lets a transaction join only a subset of channels. A free-running merge counter is provided for debug and performance monitoring.

Parameters:
- NUM_CH, 8, number of input channels (2..32).
- DATA_W, 3, data width per channel.
- CNT_W, 16, width of the merge counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_valid  input  NUM_CH  per-channel token valid.
- i_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- o_ready  output  NUM_CH  per-channel accept.
- i_ch_en  input  NUM_CH  channel participation mask.
- o_valid  output  1  merged word valid.
- o_data  output  NUM_CH*DATA_W  merged word; slot k at [k*DATA_W +: DATA_W].
- i_ready  input  1  downstream accept.
- o_busy  output  1  a transaction is in progress.
- o_merge_cnt  output  CNT_W  completed merges.

Behaviour:
- Reset (rstn=0, asynchronous) clears everything:
  - state=COLLECT; all full[k]=0; all slot data=0; en_q=0; run=0; merge count=0.
  - Outputs: o_valid=0, o_data=0, o_ready=0, o_busy=0, o_merge_cnt=0.
  - run goes to 1 on the first clk edge after rstn deasserts, so o_ready stays 0 for exactly one cycle after reset release.
- Mask latch:
  - en_q<=i_ch_en on every edge while state=COLLECT and no slot is full.
  - en_q is frozen from the first capture of a transaction until that transaction completes.
- Accept rule: o_ready[k] = run & (state==COLLECT) & ~full[k] & en_q[k].
  - A channel is captured when i_valid[k]&o_ready[k]: slot data<=i_data slice, full[k]<=1.
  - Each channel can be captured at most once per transaction.
- all_done = &(full_next | ~en_q) & (|en_q).
  - full_next includes captures made in the current cycle.
  - When all_done is true at an edge, state<=SEND.
  - o_valid is therefore high in the cycle after the last capture (1-cycle latency).
  - If all enabled channels arrive in the same cycle, SEND is entered at that edge.
- All-disabled mask (en_q=0): stay in COLLECT, produce no output, accept nothing.
- SEND state:
  - o_valid=1. o_data shows all slot registers; slots of disabled channels read 0. o_data is stable while o_valid=1.
  - All o_ready=0.
  - On o_valid&i_ready: every full[k]<=0, every slot data<=0, state<=COLLECT, o_merge_cnt increments (wraps modulo 2^CNT_W).
  - o_ready reasserts in the following cycle; back-to-back transactions therefore have a minimum period of 2 cycles.
- i_ready while in COLLECT has no effect.
- o_busy = (|full) | (state==SEND).
- i_ch_en changes during a transaction have no effect until the next transaction.
- Reset mid-transaction discards any partial data and clears the count.

Decomposition:
- Package wait_merge_pkg holds:
  - state enum {COLLECT, SEND};
  - a slice helper function returning the DATA_W-bit field for index k;
  - localparam for the total output width.
- Sub-module wait_merge_slot holds one channel's full bit and data register. It is instantiated NUM_CH times in a generate loop.
- The top level contains the FSM, mask latch, all_done reduction and counter.

Test Plan:
- Reset release, i_ch_en=8'hFF, channels 0..7 valid in cycles 0..7 with data=k -> o_ready low for 1 cycle after reset; o_valid rises the cycle after channel 7 is captured; o_data=24'o76543210; o_merge_cnt=1 after i_ready.
- All 8 channels valid in the same cycle, i_ready held at 1 -> o_valid the next cycle; merges complete every 2 cycles; count reaches 4 after 8 cycles.
- i_ch_en=8'h05, channels 0 and 2 send 3 and 5 -> o_data has 3 in slot 0, 5 in slot 2, zeros elsewhere; o_ready[1]=0 throughout.
- i_ready held at 0 for 10 cycles in SEND while i_valid toggles -> o_data stays constant; all o_ready=0; no captures occur.
- Channel 0 captured twice before the others -> second token not accepted (o_ready[0]=0) until after the merge completes.
- Assert rstn with 4 of 8 slots full -> all outputs 0 immediately; after release, a fresh 8-channel transaction merges correctly with count=1.
- CNT_W=2, run 5 merges -> o_merge_cnt wraps to 1.

Source files
------------

// File: rtl/wait_merge_pkg.sv
// Shared types and helpers for the N-channel wait-merge (join) block.
package wait_merge_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_e;

    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 3;
    localparam int CNT_W_DEF  = 16;
    localparam int MAX_CH     = 32;
    localparam int MAX_DW     = 32;
    // Widest merged word the slice helper can address
    localparam int MAX_W      = MAX_CH * MAX_DW;

    localparam logic [MAX_DW-1:0] DW_ONE = {{(MAX_DW-1){1'b0}}, 1'b1};

    function automatic logic [MAX_DW-1:0] slice(input logic [MAX_W-1:0] bus,
                                                input int unsigned k,
                                                input int unsigned w);
        return MAX_DW'(bus >> (k * w)) & ((DW_ONE << w) - DW_ONE);
    endfunction

endpackage

// File: rtl/wait_merge_sync_n_if.sv
// Handshake bundle between the channel producers, the merge block and its consumer.
interface wait_merge_sync_n_if
    import wait_merge_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic [NUM_CH-1:0]        i_valid;
    logic [NUM_CH*DATA_W-1:0] i_data;
    logic [NUM_CH-1:0]        o_ready;
    logic [NUM_CH-1:0]        i_ch_en;
    logic                     o_valid;
    logic [NUM_CH*DATA_W-1:0] o_data;
    logic                     i_ready;
    logic                     o_busy;
    logic [CNT_W-1:0]         o_merge_cnt;

    modport master (
        output i_valid, i_data, i_ch_en, i_ready,
        input  o_ready, o_valid, o_data, o_busy, o_merge_cnt
    );

    modport slave (
        input  i_valid, i_data, i_ch_en, i_ready,
        output o_ready, o_valid, o_data, o_busy, o_merge_cnt
    );

endinterface

// File: rtl/wait_merge_slot.sv
// One channel's holding slot: a full flag plus the captured token.
module wait_merge_slot #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cap,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic              full,
    output logic [DATA_W-1:0] q
);

    // Clear wins over capture; SEND never overlaps with a capture anyway
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clr) begin
            full <= 1'b0;
            q    <= '0;
        end else if (cap) begin
            full <= 1'b1;
            q    <= d;
        end
    end

endmodule

// File: rtl/wait_merge_sync_n.sv
// N-channel wait-merge: holds one token per enabled channel, then emits the
// concatenated word once every enabled channel has arrived.
module wait_merge_sync_n
    import wait_merge_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic          clk,
    input logic          rstn,
    wait_merge_sync_n_if.slave bus
);

    localparam int OUT_W = NUM_CH * DATA_W;

    state_e              state_r;
    state_e              state_nx_s;
    logic [NUM_CH-1:0]   en_q_r;
    logic                run_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NUM_CH-1:0]   full_s;
    logic [NUM_CH-1:0]   ready_s;
    logic [NUM_CH-1:0]   cap_s;
    logic [NUM_CH-1:0]   full_next_s;
    logic                collect_s;
    logic                all_done_s;
    logic                xfer_s;
    logic [MAX_W-1:0]    data_ext_s;
    logic [OUT_W-1:0]    slot_q_s;
    logic [DATA_W-1:0]   slot_d_s [NUM_CH];

    // Handshake decode and join condition, including this cycle's captures
    always_comb begin
        collect_s   = (state_r == COLLECT);
        ready_s     = {NUM_CH{run_r & collect_s}} & ~full_s & en_q_r;
        cap_s       = bus.i_valid & ready_s;
        full_next_s = full_s | cap_s;
        all_done_s  = (&(full_next_s | ~en_q_r)) & (|en_q_r);
        xfer_s      = (state_r == SEND) & bus.i_ready;
    end

    // Zero-extend the input bus so the package slice helper can address it
    always_comb begin
        data_ext_s            = '0;
        data_ext_s[OUT_W-1:0] = bus.i_data;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign slot_d_s[k] = DATA_W'(slice(data_ext_s, k, DATA_W));

        wait_merge_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk  (clk),
            .rstn (rstn),
            .cap  (cap_s[k]),
            .clr  (xfer_s),
            .d    (slot_d_s[k]),
            .full (full_s[k]),
            .q    (slot_q_s[k*DATA_W +: DATA_W])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            COLLECT: begin
                if (all_done_s) state_nx_s = SEND;
                else            state_nx_s = COLLECT;
            end
            SEND: begin
                if (bus.i_ready) state_nx_s = COLLECT;
                else             state_nx_s = SEND;
            end
            default: state_nx_s = COLLECT;
        endcase
    end

    // Run flag, mask latch (frozen once any slot fills) and merge counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_r  <= 1'b0;
            en_q_r <= '0;
            cnt_r  <= '0;
        end else begin
            run_r <= 1'b1;
            if (collect_s && !(|full_s)) begin
                en_q_r <= bus.i_ch_en;
            end
            if (xfer_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.o_ready     = ready_s;
    assign bus.o_valid     = (state_r == SEND);
    assign bus.o_data      = slot_q_s;
    assign bus.o_busy      = (|full_s) | (state_r == SEND);
    assign bus.o_merge_cnt = cnt_r;

endmodule

// File: tb/tb_wait_merge_sync_n.sv
// Directed bench for wait_merge_sync_n: 8x3-bit instance plus a 2-bit-counter wrap instance.
module tb_wait_merge_sync_n;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    logic [23:0] data_v;
    logic [7:0]  er;

    wait_merge_sync_n_if #(.NUM_CH(8), .DATA_W(3), .CNT_W(16)) bus  ();
    wait_merge_sync_n_if #(.NUM_CH(8), .DATA_W(3), .CNT_W(2))  bus2 ();

    wait_merge_sync_n #(.NUM_CH(8), .DATA_W(3), .CNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    wait_merge_sync_n #(.NUM_CH(8), .DATA_W(3), .CNT_W(2)) dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        data_v   = 24'h0;
        bus.i_valid  = 8'h00;
        bus.i_data   = 24'h0;
        bus.i_ch_en  = 8'hFF;
        bus.i_ready  = 1'b0;
        bus2.i_valid = 8'h00;
        bus2.i_data  = 24'h0;
        bus2.i_ch_en = 8'hFF;
        bus2.i_ready = 1'b0;
        repeat (2) tick();

        // reset state
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_data",  32'(bus.o_data), 32'h0);
        chk("rst_ready", 32'(bus.o_ready), 32'h0);
        chk("rst_busy",  32'(bus.o_busy), 32'h0);
        chk("rst_cnt",   32'(bus.o_merge_cnt), 32'h0);

        // test 1: release, then channels 0..7 one per cycle with data=k
        rstn = 1'b1;
        bus.i_valid = 8'h01;
        chk("t1_ready_gap", 32'(bus.o_ready), 32'h0);
        tick();
        chk("t1_ready_up", 32'(bus.o_ready), 32'hFF);
        chk("t1_busy_idle", 32'(bus.o_busy), 32'h0);
        for (int k = 0; k < 8; k++) begin
            bus.i_valid = 8'h01 << k;
            data_v[k*3 +: 3] = 3'(k);
            bus.i_data = data_v;
            tick();
            if (k < 7) begin
                er = 8'hFF << (k + 1);
                chk("t1_valid_lo", 32'(bus.o_valid), 32'h0);
                chk("t1_ready_step", 32'(bus.o_ready), 32'(er));
            end else begin
                chk("t1_valid_hi", 32'(bus.o_valid), 32'h1);
                chk("t1_data", 32'(bus.o_data), 32'(24'o76543210));
                chk("t1_ready_send", 32'(bus.o_ready), 32'h0);
            end
        end
        bus.i_valid = 8'h00;
        bus.i_ready = 1'b1;
        tick();
        chk("t1_valid_done", 32'(bus.o_valid), 32'h0);
        chk("t1_cnt", 32'(bus.o_merge_cnt), 32'h1);
        chk("t1_ready_back", 32'(bus.o_ready), 32'hFF);
        chk("t1_busy_done", 32'(bus.o_busy), 32'h0);

        // test 2: all channels together, i_ready held high -> merge every 2 cycles
        bus.i_valid = 8'hFF;
        bus.i_data  = 24'o01234567;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if ((t % 2) == 1) begin
                chk("t2_valid_hi", 32'(bus.o_valid), 32'h1);
                chk("t2_data", 32'(bus.o_data), 32'(24'o01234567));
            end else begin
                chk("t2_valid_lo", 32'(bus.o_valid), 32'h0);
                chk("t2_cnt", 32'(bus.o_merge_cnt), 32'(1 + t / 2));
            end
        end
        chk("t2_cnt_final", 32'(bus.o_merge_cnt), 32'h5);
        bus.i_valid = 8'h00;
        bus.i_ready = 1'b0;

        // test 3: mask 0x05, channels 0 and 2 carry 3 and 5
        bus.i_ch_en = 8'h05;
        tick();
        chk("t3_ready_mask", 32'(bus.o_ready), 32'h05);
        bus.i_valid = 8'hFF;
        bus.i_data  = 24'o77777573;
        tick();
        chk("t3_valid", 32'(bus.o_valid), 32'h1);
        chk("t3_data", 32'(bus.o_data), 32'(24'o00000503));
        chk("t3_ready_send", 32'(bus.o_ready), 32'h0);

        // test 4: stall in SEND for 10 cycles while inputs toggle
        for (int i = 0; i < 10; i++) begin
            bus.i_valid = ((i % 2) == 1) ? 8'hFF : 8'h00;
            bus.i_data  = 24'($urandom);
            tick();
            chk("t4_data_hold", 32'(bus.o_data), 32'(24'o00000503));
            chk("t4_ready_lo", 32'(bus.o_ready), 32'h0);
            chk("t4_valid_hold", 32'(bus.o_valid), 32'h1);
        end
        bus.i_valid = 8'h00;
        bus.i_ready = 1'b1;
        bus.i_ch_en = 8'hFF;
        tick();
        chk("t4_cnt", 32'(bus.o_merge_cnt), 32'h6);
        chk("t4_ready_old_mask", 32'(bus.o_ready), 32'h05);
        bus.i_ready = 1'b0;
        tick();
        chk("t4_ready_new_mask", 32'(bus.o_ready), 32'hFF);

        // test 5: channel 0 offers a second token before the others arrive
        bus.i_valid = 8'h01;
        bus.i_data  = 24'o1;
        tick();
        chk("t5_ready_first", 32'(bus.o_ready), 32'hFE);
        chk("t5_busy", 32'(bus.o_busy), 32'h1);
        bus.i_data = 24'o2;
        tick();
        chk("t5_ready_second", 32'(bus.o_ready), 32'hFE);
        chk("t5_data_kept", 32'(bus.o_data), 32'(24'o1));
        bus.i_valid = 8'hFE;
        bus.i_data  = 24'o76543216;
        tick();
        chk("t5_valid", 32'(bus.o_valid), 32'h1);
        chk("t5_data", 32'(bus.o_data), 32'(24'o76543211));
        bus.i_valid = 8'h01;
        bus.i_data  = 24'o5;
        bus.i_ready = 1'b1;
        tick();
        chk("t5_cnt", 32'(bus.o_merge_cnt), 32'h7);
        chk("t5_ready_reopen", 32'(bus.o_ready), 32'hFF);
        bus.i_ready = 1'b0;
        tick();
        chk("t5_ready_recap", 32'(bus.o_ready), 32'hFE);

        // test 6: reset with 4 of 8 slots full, then a fresh transaction
        bus.i_valid = 8'h0E;
        bus.i_data  = 24'o3215;
        tick();
        chk("t6_ready_half", 32'(bus.o_ready), 32'hF0);
        chk("t6_data_half", 32'(bus.o_data), 32'(24'o3215));
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(bus.o_ready), 32'h0);
        chk("t6_rst_valid", 32'(bus.o_valid), 32'h0);
        chk("t6_rst_data", 32'(bus.o_data), 32'h0);
        chk("t6_rst_busy", 32'(bus.o_busy), 32'h0);
        chk("t6_rst_cnt", 32'(bus.o_merge_cnt), 32'h0);
        bus.i_valid = 8'h00;
        tick();
        rstn = 1'b1;
        chk("t6_ready_gap", 32'(bus.o_ready), 32'h0);
        tick();
        chk("t6_ready_up", 32'(bus.o_ready), 32'hFF);
        bus.i_valid = 8'hFF;
        bus.i_data  = 24'o13572460;
        tick();
        chk("t6_valid", 32'(bus.o_valid), 32'h1);
        chk("t6_data", 32'(bus.o_data), 32'(24'o13572460));
        bus.i_valid = 8'h00;
        bus.i_ready = 1'b1;
        tick();
        chk("t6_cnt", 32'(bus.o_merge_cnt), 32'h1);
        chk("t6_valid_lo", 32'(bus.o_valid), 32'h0);
        bus.i_ready = 1'b0;

        // all-disabled mask: nothing accepted, nothing produced
        bus.i_ch_en = 8'h00;
        tick();
        bus.i_valid = 8'hFF;
        repeat (2) tick();
        chk("t8_ready_none", 32'(bus.o_ready), 32'h0);
        chk("t8_valid_none", 32'(bus.o_valid), 32'h0);
        chk("t8_busy_none", 32'(bus.o_busy), 32'h0);
        chk("t8_cnt_same", 32'(bus.o_merge_cnt), 32'h1);
        bus.i_valid = 8'h00;

        // test 7: 2-bit counter wraps after 4 merges
        bus2.i_valid = 8'hFF;
        bus2.i_data  = 24'o44444444;
        bus2.i_ready = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 8) chk("t7_cnt_wrap0", 32'(bus2.o_merge_cnt), 32'h0);
        end
        chk("t7_cnt_wrap1", 32'(bus2.o_merge_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
